// File: rtl/per_count_if.sv
// Button-period bus: timepulse/button inputs and the period strobe output of per_count.
interface per_count_if #(
    parameter int unsigned PER_WIDTH = 24
);
    logic                 tp_i;
    logic                 btn_i;
    logic [PER_WIDTH-1:0] btn_per_o;
    logic                 btn_per_valid;
    logic                 meas_active_o;

    modport master (
        output tp_i,
        output btn_i,
        input  btn_per_o,
        input  btn_per_valid,
        input  meas_active_o
    );

    modport slave (
        input  tp_i,
        input  btn_i,
        output btn_per_o,
        output btn_per_valid,
        output meas_active_o
    );
endinterface

// File: rtl/per_count.sv
// Measures timepulses between successive button presses and strobes one period per press.
// Optional 4-sample moving average of the output when PER_COUNT_AVG_EN is defined.
module per_count #(
    parameter int unsigned PER_WIDTH  = 24,
    parameter int unsigned TIMEOUT_TP = 16384
) (
    input logic          clk_i,
    input logic          rst_ni,
    per_count_if.slave   bus
);
    typedef enum logic {StIdle, StCount} state_e;

    localparam logic [PER_WIDTH:0] Timeout = (PER_WIDTH + 1)'(TIMEOUT_TP);

    state_e               state_q, state_d;
    logic                 btn_q;
    logic [PER_WIDTH-1:0] cnt_q, cnt_d;
    logic [PER_WIDTH-1:0] per_q, per_d;
    logic                 valid_q, valid_d;
    logic [PER_WIDTH:0]   tot;
    logic [PER_WIDTH-1:0] period;
    logic                 press;
    logic                 sample;
    logic                 timeout;

    assign press  = bus.btn_i & ~btn_q;
    // A timepulse in the press cycle still belongs to the closing period.
    assign tot    = {1'b0, cnt_q} + (PER_WIDTH + 1)'(bus.tp_i);
    assign period = tot[PER_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        sample  = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (press) state_d = StCount;
            end
            StCount: begin
                if (press) begin
                    cnt_d   = '0;
                    sample  = 1'b1;
                    valid_d = 1'b1;
                end else if (tot == Timeout) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    timeout = 1'b1;
                end else begin
                    cnt_d = period;
                end
            end
        endcase
    end

`ifdef PER_COUNT_AVG_EN
    logic [PER_WIDTH-1:0] hist_q [4];
    logic [1:0]           ptr_q;
    logic                 hist_vld_q;
    logic [PER_WIDTH+1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (sample) begin
            // An empty history is primed with four copies of the first sample.
            if (!hist_vld_q) sum_d = {period, 2'b00};
            else             sum_d = sum_q - {2'b00, hist_q[ptr_q]} + {2'b00, period};
        end
        per_d = sample ? sum_d[PER_WIDTH+1:2] : per_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            ptr_q      <= '0;
            hist_vld_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            sum_q <= sum_d;
            if (sample) begin
                if (!hist_vld_q) begin
                    for (int i = 0; i < 4; i++) hist_q[i] <= period;
                    hist_vld_q <= 1'b1;
                end else begin
                    hist_q[ptr_q] <= period;
                    ptr_q         <= ptr_q + 2'd1;
                end
            end else if (timeout) begin
                hist_vld_q <= 1'b0;
                ptr_q      <= '0;
            end
        end
    end
`else
    always_comb begin
        per_d = sample ? period : per_q;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            btn_q   <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= bus.btn_i;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            valid_q <= valid_d;
        end
    end

    assign bus.btn_per_o     = per_q;
    assign bus.btn_per_valid = valid_q;
    assign bus.meas_active_o = (state_q == StCount);
endmodule

// File: tb/tb_per_count.sv
// Self-checking bench for per_count: directed scenarios plus random presses against a
// behavioural model of press-to-press timepulse counting.
module tb_per_count;
    localparam int unsigned W  = 24;
    localparam int unsigned TO = 16384;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    per_count_if #(.PER_WIDTH(W)) bus ();

    per_count #(
        .PER_WIDTH (W),
        .TIMEOUT_TP(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_prev, m_armed, m_valid;
    int m_cnt, m_per;
    int hist[$];

    int obs_strobes = 0;
    int obs_last    = 0;
    int tp_seen     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int emit_val(input int p);
`ifdef PER_COUNT_AVG_EN
        int s = 0;
        if (hist.size() == 0) begin
            repeat (4) hist.push_back(p);
        end else begin
            void'(hist.pop_front());
            hist.push_back(p);
        end
        foreach (hist[i]) s += hist[i];
        return s / 4;
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        m_prev  = 0;
        m_armed = 0;
        m_valid = 0;
        m_cnt   = 0;
        m_per   = 0;
        hist.delete();
    endtask

    task automatic tick(input logic b, input logic t);
        bit press;
        int tot;
        bus.btn_i = b;
        bus.tp_i  = t;
        if (t) tp_seen++;
        @(posedge clk);
        press   = b && !m_prev;
        m_prev  = b;
        m_valid = 0;
        if (m_armed) begin
            tot = m_cnt + int'(t);
            if (press) begin
                m_valid = 1;
                m_per   = emit_val(tot);
                m_cnt   = 0;
            end else if (tot == int'(TO)) begin
                m_armed = 0;
                m_cnt   = 0;
                hist.delete();
            end else begin
                m_cnt = tot;
            end
        end else if (press) begin
            m_armed = 1;
            m_cnt   = 0;
        end
        #1;
        check("valid", {31'd0, bus.btn_per_valid}, {31'd0, m_valid});
        check("per", {8'd0, bus.btn_per_o}, m_per);
        check("active", {31'd0, bus.meas_active_o}, {31'd0, m_armed});
        if (bus.btn_per_valid === 1'b1) begin
            obs_strobes++;
            obs_last = int'(bus.btn_per_o);
        end
    endtask

    task automatic tp_run(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b0);
            tick(1'b0, 1'b1);
        end
    endtask

    task automatic press(input logic t);
        tick(1'b1, t);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_per"}, {8'd0, bus.btn_per_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.btn_per_valid}, 32'd0);
        check({tag, "_active"}, {31'd0, bus.meas_active_o}, 32'd0);
    endtask

    task automatic do_reset();
        bus.btn_i = 1'b0;
        bus.tp_i  = 1'b0;
        rst_ni    = 1'b0;
        #1;
        check_zero("rst");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("rst");
        end
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        int s0, v1, t0;
        model_reset();
        bus.btn_i = 1'b0;
        bus.tp_i  = 1'b0;

        // 1: basic period
        do_reset();
        s0 = obs_strobes;
        press(1'b0);
        tp_run(2441);
        check("t1_active", {31'd0, bus.meas_active_o}, 32'd1);
        press(1'b0);
        check("t1_count", obs_strobes - s0, 1);
        check("t1_value", obs_last, 2441);
        tick(1'b0, 1'b0);

        // 2: chained presses
        do_reset();
        s0 = obs_strobes;
        press(1'b0);
        tp_run(1000);
        press(1'b0);
        v1 = obs_last;
        tp_run(500);
        press(1'b0);
        tick(1'b0, 1'b0);
        check("t2_count", obs_strobes - s0, 2);
        check("t2_first", v1, 1000);
`ifdef PER_COUNT_AVG_EN
        check("t2_second", obs_last, 875);
`else
        check("t2_second", obs_last, 500);
`endif

        // 3: timepulse coincident with the closing press
        do_reset();
        press(1'b0);
        tick(1'b0, 1'b0);
        tp_run(9);
        press(1'b1);
        tick(1'b0, 1'b0);
        check("t3_value", obs_last, 10);

        // 4: timeout, then re-arm
        do_reset();
        s0 = obs_strobes;
        press(1'b0);
        tp_run(int'(TO));
        check("t4_active", {31'd0, bus.meas_active_o}, 32'd0);
        check("t4_none", obs_strobes - s0, 0);
        press(1'b0);
        check("t4_arm_none", obs_strobes - s0, 0);
        tp_run(50);
        press(1'b0);
        check("t4_count", obs_strobes - s0, 1);
        check("t4_value", obs_last, 50);

        // 5: reset discards a pending measurement
        do_reset();
        press(1'b0);
        tp_run(300);
        s0 = obs_strobes;
        do_reset();
        press(1'b0);
        tp_run(40);
        press(1'b0);
        tick(1'b0, 1'b0);
        check("t5_count", obs_strobes - s0, 1);
        check("t5_value", obs_last, 40);

        // 6: long hold produces no extra events
        do_reset();
        s0 = obs_strobes;
        press(1'b0);
        t0 = tp_seen;
        repeat (10000) tick(1'b1, ($urandom_range(0, 3) == 0));
        tick(1'b0, 1'b0);
        press(1'b1);
        check("t6_count", obs_strobes - s0, 1);
        check("t6_value", obs_last, tp_seen - t0);
        tick(1'b0, 1'b0);

        // 7: press wins over coincident timeout
        do_reset();
        press(1'b0);
        tp_run(int'(TO) - 1);
        press(1'b1);
        check("t7_value", obs_last, int'(TO));
        check("t7_active", {31'd0, bus.meas_active_o}, 32'd1);

        // 8: zero-length period
        tick(1'b0, 1'b0);
        press(1'b0);
`ifdef PER_COUNT_AVG_EN
        check("t8_value", obs_last, int'(TO) * 3 / 4);
`else
        check("t8_value", obs_last, 0);
`endif

        // Random presses, gaps and occasional resets; checked every cycle by the model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tp_run($urandom_range(0, 80));
            if ($urandom_range(0, 15) == 0) do_reset();
            press(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) tick(1'b1, 1'($urandom_range(0, 1)));
        end
        tick(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/per_count.md
Name: per_count

Overview:
- Measures the time between successive button presses, in timepulse units.
- Sits directly upstream of the period-to-BPM converter and drives its btn_per_i / btn_per_valid inputs.
- Takes a debounced button level and a one-clock timepulse strobe, produced elsewhere as one pulse every 5120 clocks at 25 MHz.
- Emits one 24-bit period sample per press, after the first press of a sequence.

Parameters:
- PER_WIDTH, 24, width of period counter and output.
- TIMEOUT_TP, 16384, timepulse count at which a pending measurement is abandoned (about 3.4 s, below 20 BPM).

Ports:
- clk_i  input  1  system clock (25 MHz).
- rst_ni  input  1  reset; one clock; asynchronous, active-low.
- tp_i  input  1  timepulse strobe, one clock wide.
- btn_i  input  1  debounced button level, synchronous to clk_i.
- btn_per_o  output  PER_WIDTH  measured period in timepulses.
- btn_per_valid  output  1  one-clock strobe; btn_per_o is valid on this cycle.
- meas_active_o  output  1  high while a measurement is in progress (state COUNT).

Behaviour:
- Reset (rst_ni low, async): btn_q=0, state=IDLE, cnt=0, btn_per_o=0, btn_per_valid=0, meas_active_o=0.
- Press event: btn_i=1 and btn_q=0, where btn_q is btn_i registered. Holding the button generates no further events. Release has no effect.
- State IDLE:
  - cnt held at 0.
  - On a press event, go to COUNT with cnt=0. No output.
- State COUNT:
  - Each cycle with tp_i=1, cnt increments by 1.
  - On a press event, let P = cnt + tp_i. A timepulse in the same cycle counts toward the closing period.
  - Register btn_per_o=P and pulse btn_per_valid=1 on the next cycle. Latency is one clock from the press-event cycle.
  - Also on the press event, cnt reloads to 0 and the state stays COUNT. Presses chain, so every press after the first yields a sample.
  - P=0 is legal (two presses with no timepulse between). It is output as 0; the downstream block clamps it.
  - Timeout: if cnt + tp_i reaches TIMEOUT_TP with no press event in that cycle, go to IDLE, cnt=0, no output.
  - If a press event and the timeout coincide, the press wins: output P=TIMEOUT_TP and stay in COUNT.
- btn_per_o holds its last value between strobes.
- btn_per_valid is never high on two consecutive cycles.
- No ready input: the downstream block ignores strobes while busy. Minimum press spacing is enforced by the debouncer, not here.
- meas_active_o = (state==COUNT), registered.
- cnt never exceeds TIMEOUT_TP, so it never wraps.
- Reset asserted mid-measurement: discard the measurement. After release, the first press only arms the block.

Optional Feature:
- Macro: PER_COUNT_AVG_EN.
- Defined:
  - A 4-entry history of periods and a 26-bit running sum are kept.
  - On each press event in COUNT, the oldest entry is replaced by P.
  - If the history is empty (first sample after IDLE or reset), all 4 entries are loaded with P.
  - btn_per_o = (sum of 4 entries) >> 2, truncated, in the same strobe cycle. Latency stays one clock.
  - History is emptied on reset and on timeout.
- Not defined: btn_per_o = P raw; no history registers are synthesised.

Test Plan:
1. Reset release, press, 2441 tp pulses, press -> one btn_per_valid one clock after the second press, btn_per_o=2441, meas_active_o=1 throughout.
2. Three presses spaced 1000 then 500 tp -> strobes with 1000 then 500. With PER_COUNT_AVG_EN: 1000, then 875.
3. Press, tp_i and second press in the same clock as the 10th tp -> btn_per_o=10.
4. Press, then no press for 16384 tp -> meas_active_o falls, no strobe. Next press only arms; a following press after 50 tp outputs 50.
5. Press, 300 tp, rst_ni low for 3 clocks, press, 40 tp, press -> only one strobe, value 40. Outputs are 0 during reset.
6. btn_i held high 10000 clocks with tp pulses, then released and pressed again -> exactly one strobe with the tp count between the two rising edges.
